// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: load/value/blank inputs and scanned segment outputs of the 7-segment driver
// master: drives load, value (4*DIGITS), dp_in (DIGITS), blank; receives seg (7), dp, an (DIGITS), frame_done
// slave : the driver side, directions reversed
interface seg7_scan_driver_if #(parameter int DIGITS = 4);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic                  blank;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;
  logic                  frame_done;
  modport master (output load, value, dp_in, blank, input seg, dp, an, frame_done);
  modport slave (input load, value, dp_in, blank, output seg, dp, an, frame_done);
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed hex driver scanning DIGITS 7-segment digits at REFRESH_DIV clk per digit
// clk, rst : clock and synchronous active-high reset
// bus      : seg7_scan_driver_if.slave (load/value/dp_in/blank in; seg/dp/an/frame_done out, all registered)
// SEG7_LEADING_ZERO_BLANK_EN defined: digits above the most-significant nonzero digit show seg=0
module seg7_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input logic               clk,
  input logic               rst,
  seg7_scan_driver_if.slave bus
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int PW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d, sel;
  logic                fd_q, fd_d;
  logic                tc, last, sup;
  logic [3:0]          nib;
  function automatic logic [6:0] hex_decode(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;
      4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;
      4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction
  always_comb begin
    tc = presc_q == PW'(REFRESH_DIV - 1);
    last = idx_q == IW'(DIGITS - 1);
    presc_d = tc ? '0 : presc_q + 1'b1;
    idx_d = tc ? (last ? '0 : idx_q + 1'b1) : idx_q;
    shadow_val_d = bus.load ? bus.value : shadow_val_q;
    shadow_dp_d = bus.load ? bus.dp_in : shadow_dp_q;
    // outputs come from the pre-edge shadow so a coincident load never mixes nibbles
    sel = DIGITS'(1) << idx_q;
    nib = 4'(shadow_val_q >> {idx_q, 2'b00});
    sup = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // suppressed when this digit and every digit above it are zero; digit 0 always shown
    sup = idx_q != '0;
    for (int k = 0; k < DIGITS; k++)
      if (k >= int'(idx_q) && shadow_val_q[4*k +: 4] != 4'd0) sup = 1'b0;
`endif
    an_d = bus.blank ? '0 : sel;
    seg_d = (bus.blank || sup) ? '0 : hex_decode(nib);
    dp_d = !bus.blank && |(shadow_dp_q & sel);
    fd_d = tc && last;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_val_q <= '0;
      shadow_dp_q <= '0;
      presc_q <= '0;
      idx_q <= '0;
      seg_q <= '0;
      dp_q <= 1'b0;
      an_q <= '0;
      fd_q <= 1'b0;
    end else begin
      shadow_val_q <= shadow_val_d;
      shadow_dp_q <= shadow_dp_d;
      presc_q <= presc_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
      an_q <= an_d;
      fd_q <= fd_d;
    end
  end
  assign bus.seg = seg_q;
  assign bus.dp = dp_q;
  assign bus.an = an_q;
  assign bus.frame_done = fd_q;
endmodule
